f_pc_gen: RTL and testbench

F_PC_GEN -- requirements
Module: f_pc_gen

---
 rtl/f_pc_gen_pkg.sv | 21 ++
 rtl/f_pc_exc_chk.sv | 20 ++
 rtl/f_pc_gen.sv | 90 +++++++++
 tb/tb_f_pc_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/f_pc_gen_pkg.sv
// Shared CPU constants for instruction fetch: reset/exception vectors, legal
// instruction window and fetch exception codes, plus the next-PC source select.
package f_pc_gen_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] IM_LO    = 32'h0000_3000;
    localparam logic [31:0] IM_HI    = 32'h0000_6FFF;

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_EXC,
        NPC_ERET,
        NPC_HOLD,
        NPC_REDIR
    } npc_sel_e;

endpackage

// File: rtl/f_pc_exc_chk.sv
// Fetch address check: flags AdEL for a misaligned PC or one outside the
// instruction memory window.
module f_pc_exc_chk
    import f_pc_gen_pkg::*;
#(
    parameter logic [31:0] IM_LO = f_pc_gen_pkg::IM_LO,
    parameter logic [31:0] IM_HI = f_pc_gen_pkg::IM_HI
) (
    input  logic [31:0] i_pc,
    output logic [4:0]  o_exc_code
);

    logic w_misaligned;
    logic w_out_of_range;

    assign w_misaligned   = |i_pc[1:0];
    assign w_out_of_range = (i_pc < IM_LO) || (i_pc > IM_HI);
    assign o_exc_code     = (w_misaligned || w_out_of_range) ? EXC_ADEL : EXC_NONE;

endmodule

// File: rtl/f_pc_gen.sv
// F-stage PC generator: PC register with prioritised next-PC selection,
// fetch squashing, delay-slot flag and accepted-instruction counter.
module f_pc_gen
    import f_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = f_pc_gen_pkg::RESET_PC,
    parameter logic [31:0] EXC_PC   = f_pc_gen_pkg::EXC_PC,
    parameter logic [31:0] IM_LO    = f_pc_gen_pkg::IM_LO,
    parameter logic [31:0] IM_HI    = f_pc_gen_pkg::IM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Req,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    input  logic        D_redirect,
    input  logic [31:0] D_target,
    input  logic        D_is_bj,
    input  logic [31:0] IM_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_instr,
    output logic [4:0]  F_ExcCode,
    output logic        F_BD,
    output logic [31:0] F_fetch_cnt
);

    logic [31:0] r_pc;
    logic [31:0] r_fetch_cnt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic [4:0]  w_exc_code;
    logic        w_accept;
    npc_sel_e    w_sel;

    assign w_pc_plus4 = r_pc + 32'd4;

    // A redirect under Stall is dropped: D presents it again once unstalled.
    always_comb begin
        w_sel = NPC_SEQ;
        if (Req)
            w_sel = NPC_EXC;
        else if (D_eret)
            w_sel = NPC_ERET;
        else if (Stall)
            w_sel = NPC_HOLD;
        else if (D_redirect)
            w_sel = NPC_REDIR;
    end

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (w_sel)
            NPC_EXC:   w_next_pc = EXC_PC;
            NPC_ERET:  w_next_pc = EPC;
            NPC_HOLD:  w_next_pc = r_pc;
            NPC_REDIR: w_next_pc = D_target;
            default:   w_next_pc = w_pc_plus4;
        endcase
    end

    assign w_accept = !Req && !Stall && !D_eret;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_fetch_cnt <= 32'd0;
        end else begin
            r_pc <= w_next_pc;
            if (w_accept)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    f_pc_exc_chk #(
        .IM_LO (IM_LO),
        .IM_HI (IM_HI)
    ) u_exc_chk (
        .i_pc       (r_pc),
        .o_exc_code (w_exc_code)
    );

    // eret has no delay slot, so whatever F fetched alongside it is discarded.
    assign F_PC        = r_pc;
    assign F_ExcCode   = w_exc_code;
    assign F_instr     = ((w_exc_code != EXC_NONE) || D_eret) ? 32'h0 : IM_rdata;
    assign F_BD        = D_is_bj && !D_eret;
    assign F_fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_f_pc_gen.sv
// Bench for f_pc_gen: spec-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_f_pc_gen;

    localparam logic [31:0] T_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] T_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] T_IM_LO    = 32'h0000_3000;
    localparam logic [31:0] T_IM_HI    = 32'h0000_6FFF;

    logic        clk = 1'b0;
    logic        reset, Stall, Req, D_eret, D_redirect, D_is_bj;
    logic [31:0] EPC, D_target, IM_rdata;
    logic [31:0] F_PC, F_instr, F_fetch_cnt;
    logic [4:0]  F_ExcCode;
    logic        F_BD;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    assign IM_rdata = mem_word(F_PC);

    f_pc_gen dut (
        .clk         (clk),
        .reset       (reset),
        .Stall       (Stall),
        .Req         (Req),
        .D_eret      (D_eret),
        .EPC         (EPC),
        .D_redirect  (D_redirect),
        .D_target    (D_target),
        .D_is_bj     (D_is_bj),
        .IM_rdata    (IM_rdata),
        .F_PC        (F_PC),
        .F_instr     (F_instr),
        .F_ExcCode   (F_ExcCode),
        .F_BD        (F_BD),
        .F_fetch_cnt (F_fetch_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_valid = 1'b0;

    function automatic logic [4:0] exp_exc(input logic [31:0] pc);
        if (pc[1:0] != 2'b00 || pc < T_IM_LO || pc > T_IM_HI)
            return 5'd4;
        return 5'd0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pc    <= T_RESET_PC;
            m_cnt   <= 32'd0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (Req)             m_pc <= T_EXC_PC;
            else if (D_eret)     m_pc <= EPC;
            else if (Stall)      m_pc <= m_pc;
            else if (D_redirect) m_pc <= D_target;
            else                 m_pc <= m_pc + 32'd4;
            if (!Req && !Stall && !D_eret)
                m_cnt <= m_cnt + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_F_PC", F_PC, m_pc);
            chk("model_F_fetch_cnt", F_fetch_cnt, m_cnt);
            chk("model_F_ExcCode", {27'd0, F_ExcCode}, {27'd0, exp_exc(m_pc)});
            chk("model_F_instr", F_instr,
                (exp_exc(m_pc) != 5'd0 || D_eret) ? 32'h0 : mem_word(m_pc));
            chk("model_F_BD", {31'd0, F_BD}, {31'd0, D_is_bj && !D_eret});
        end
    end

    task automatic drive(input logic rst, input logic st, input logic rq, input logic er,
                         input logic [31:0] epc, input logic rd, input logic [31:0] tgt,
                         input logic bj);
        reset = rst; Stall = st; Req = rq; D_eret = er;
        EPC = epc; D_redirect = rd; D_target = tgt; D_is_bj = bj;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset while stalled, excepting and redirecting
        drive(1, 1, 1, 0, 32'h0, 1, 32'h3100, 1);
        tick(); tick();
        chk("rst_pc", F_PC, 32'h3000);
        chk("rst_cnt", F_fetch_cnt, 32'd0);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
        #1;
        chk("rst_exc", {27'd0, F_ExcCode}, 32'd0);
        chk("rst_bd", {31'd0, F_BD}, 32'd1);
        idle();
        tick(); chk("seq_pc1", F_PC, 32'h3004); chk("seq_cnt1", F_fetch_cnt, 32'd1);
        tick(); chk("seq_pc2", F_PC, 32'h3008); chk("seq_cnt2", F_fetch_cnt, 32'd2);
        tick(); chk("seq_pc3", F_PC, 32'h300C); chk("seq_cnt3", F_fetch_cnt, 32'd3);
        tick(); chk("seq_pc4", F_PC, 32'h3010);

        // Req beats Stall
        drive(0, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tick(); chk("req_stall_pc", F_PC, 32'h4180); chk("req_stall_cnt", F_fetch_cnt, 32'd4);

        // eret back to 3020
        drive(0, 0, 0, 1, 32'h3020, 0, 32'h0, 1);
        #1; chk("eret1_instr", F_instr, 32'h0); chk("eret1_bd", {31'd0, F_BD}, 32'd0);
        tick(); chk("eret1_pc", F_PC, 32'h3020); chk("eret1_cnt", F_fetch_cnt, 32'd4);

        // Branch redirect with delay slot flag
        drive(0, 0, 0, 0, 32'h0, 1, 32'h3100, 1);
        #1; chk("redir_bd", {31'd0, F_BD}, 32'd1);
        tick(); chk("redir_pc", F_PC, 32'h3100); chk("redir_cnt", F_fetch_cnt, 32'd5);

        // Walk to 4190 inside the handler, then eret to 3024
        drive(0, 0, 1, 0, 32'h0, 0, 32'h0, 0);
        tick(); idle();
        repeat (4) tick();
        chk("h_pc", F_PC, 32'h4190); chk("h_cnt", F_fetch_cnt, 32'd9);
        drive(0, 0, 0, 1, 32'h3024, 0, 32'h0, 1);
        #1; chk("eret2_instr", F_instr, 32'h0); chk("eret2_bd", {31'd0, F_BD}, 32'd0);
        tick(); chk("eret2_pc", F_PC, 32'h3024);

        // Stall swallows a simultaneous redirect
        drive(0, 1, 0, 0, 32'h0, 1, 32'h3200, 0);
        tick(); chk("stall_redir_pc", F_PC, 32'h3024); chk("stall_redir_cnt", F_fetch_cnt, 32'd9);

        // Misaligned target faults but still advances
        drive(0, 0, 0, 0, 32'h0, 1, 32'h3102, 0);
        tick(); idle(); #1;
        chk("mis_pc", F_PC, 32'h3102);
        chk("mis_exc", {27'd0, F_ExcCode}, 32'd4);
        chk("mis_instr", F_instr, 32'h0);
        tick(); chk("mis_next_pc", F_PC, 32'h3106); chk("mis_next_cnt", F_fetch_cnt, 32'd11);

        // 32-bit wrap of PC+4
        drive(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);
        tick(); idle(); chk("top_exc", {27'd0, F_ExcCode}, 32'd4);
        tick(); chk("wrap_pc", F_PC, 32'h0); chk("wrap_exc", {27'd0, F_ExcCode}, 32'd4);

        // Window upper edge
        drive(0, 0, 0, 0, 32'h0, 1, 32'h6FFC, 0);
        tick(); idle(); chk("hi_in_exc", {27'd0, F_ExcCode}, 32'd0);
        tick(); chk("hi_out_pc", F_PC, 32'h7000); chk("hi_out_exc", {27'd0, F_ExcCode}, 32'd4);

        // Window lower edge
        drive(0, 0, 0, 0, 32'h0, 1, 32'h2FFC, 0);
        tick(); idle(); chk("lo_out_exc", {27'd0, F_ExcCode}, 32'd4);
        tick(); chk("lo_in_pc", F_PC, 32'h3000); chk("lo_in_exc", {27'd0, F_ExcCode}, 32'd0);
        chk("lo_in_cnt", F_fetch_cnt, 32'd17);

        // Reset during Stall+Req discards everything
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tick(); chk("rst2_pc", F_PC, 32'h3000); chk("rst2_cnt", F_fetch_cnt, 32'd0);
        idle();
        tick(); chk("rst2_next_pc", F_PC, 32'h3004); chk("rst2_next_cnt", F_fetch_cnt, 32'd1);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
